fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. It owns the PC register and issues sequential word fetches to instruction memory over a valid/ready request channel with in-order responses. Fetched instruction/PC pairs are buffered in a small FIFO and presented to the IF/ID register. It obeys the hazard unit's stall and the decode stage's branch/jump redirect (`pc_src`/`new_pc`), and drops responses that are still in flight when a redirect occurs.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and payload types for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered fetch: the instruction word together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Force a target address onto a word boundary.
   function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} pairs sitting between fetch and decode.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  fetch_entry_t     pushData_i,
   output fetch_entry_t     headData_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doPush;
   logic             doPop;

   function automatic logic [PTR_W-1:0] bumpPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Status flags, qualified push/pop and next pointer/count; clear wins over everything.
   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CNT_W'(DEPTH));
      doPop   = pop_i & ~empty_o & ~clear_i;
      doPush  = push_i & (~full_o | doPop) & ~clear_i;
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (clear_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPop) begin
            rdPtr_d = bumpPtr(rdPtr_q);
         end
         if (doPush) begin
            wrPtr_d = bumpPtr(wrPtr_q);
         end
         count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
      end
      headData_o = mem_q[rdPtr_q];
      count_o    = count_q;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and buffers results for decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_if,
   input  logic            pc_src,
   input  logic [XLEN-1:0] new_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid_if,
   output logic [XLEN-1:0] instr_if,
   output logic [XLEN-1:0] pc_if
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] fifoCount;
   logic             fifoEmpty;
   logic             fifoFull;
   logic             pop;
   logic             accept;
   logic             rspPush;
   logic [31:0]      creditSum;
   fetch_entry_t     headEntry;
   fetch_entry_t     pushEntry;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst),
      .push_i     (rspPush),
      .pop_i      (pop),
      .clear_i    (pc_src),
      .pushData_i (pushEntry),
      .headData_o (headEntry),
      .count_o    (fifoCount),
      .empty_o    (fifoEmpty),
      .full_o     (fifoFull)
   );

   // Handshake, credit and push decisions. Requests in flight plus buffered entries never exceed the
   // buffer depth, so every response has a slot waiting. The PC of the oldest live request is the
   // current PC minus one word per outstanding request, which holds once all stale responses are gone.
   always_comb begin
      pop            = ~fifoEmpty & ~stall_if & ~pc_src;
      creditSum      = 32'(outstanding_q) + 32'(fifoCount) - 32'(pop);
      imem_req_valid = rst & (creditSum < 32'(FIFO_DEPTH));
      imem_req_addr  = pc_q;
      accept         = imem_req_valid & imem_req_ready;
      rspPush        = imem_rsp_valid & (drop_q == '0) & ~pc_src;
      pushEntry.pc    = pc_q - (XLEN'(outstanding_q) << 2);
      pushEntry.instr = imem_rsp_data;
      instr_valid_if = ~fifoEmpty;
      instr_if       = fifoEmpty ? NOP_INSTR : headEntry.instr;
      pc_if          = fifoEmpty ? '0 : headEntry.pc;
   end

   // Next PC and counters. On a redirect everything still in flight, including this cycle's accept,
   // becomes stale and must be discarded when it returns.
   always_comb begin
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
      drop_d        = drop_q;
      pc_d          = pc_q;
      if (pc_src) begin
         pc_d   = alignPc(new_pc);
         drop_d = outstanding_d;
      end else begin
         if (accept) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
      end
   end

   // Fetch control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   // A response must never land in a full buffer unless the head leaves in the same cycle.
   noOverflow: assert property (@(posedge clk) disable iff (!rst) !(rspPush && fifoFull && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised self-checking bench for fetch_unit with an in-order, variable-latency memory model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } memReq_t;

   logic        clk;
   logic        rst;
   logic        stall_if;
   logic        pc_src;
   logic [31:0] new_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid_if;
   logic [31:0] instr_if;
   logic [31:0] pc_if;

   int asserts = 0;
   int fails   = 0;
   int cycleNum = 0;
   int latMin = 1;
   int latMax = 1;

   memReq_t      memQ[$];
   fetch_entry_t bufQ[$];
   logic [31:0]  modelPc = RST_PC;
   bit           prevHold = 0;
   logic [31:0]  prevAddr = 32'h0;

   logic        lastValid;
   logic [31:0] lastPcIf;
   logic [31:0] lastInstr;
   logic        lastReqValid;
   logic [31:0] lastReqAddr;

   fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_if       (stall_if),
      .pc_src         (pc_src),
      .new_pc         (new_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid_if (instr_valid_if),
      .instr_if       (instr_if),
      .pc_if          (pc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] memData(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %h required %h", name, cycleNum, act, exp);
      end
   endtask

   // Compare the DUT against the reference model for this cycle, then advance the model.
   task automatic checkOutput();
      logic        expValid;
      logic [31:0] expInstr;
      logic [31:0] expPc;
      logic        expReq;
      logic        popM;
      logic        acc;
      memReq_t     e;
      lastValid    = instr_valid_if;
      lastPcIf     = pc_if;
      lastInstr    = instr_if;
      lastReqValid = imem_req_valid;
      lastReqAddr  = imem_req_addr;
      if (!rst) begin
         memQ.delete();
         bufQ.delete();
         modelPc  = RST_PC;
         prevHold = 0;
         check("rstReqValid", {31'b0, imem_req_valid}, 32'h0);
         check("rstInstrValid", {31'b0, instr_valid_if}, 32'h0);
         check("rstInstr", instr_if, NOP_INSTR);
         check("rstPcIf", pc_if, 32'h0);
         return;
      end
      expValid = bufQ.size() > 0;
      expInstr = expValid ? bufQ[0].instr : NOP_INSTR;
      expPc    = expValid ? bufQ[0].pc : 32'h0;
      popM     = expValid && !stall_if && !pc_src;
      expReq   = (memQ.size() + bufQ.size() - int'(popM)) < DEPTH;
      check("instrValid", {31'b0, instr_valid_if}, {31'b0, expValid});
      check("instr", instr_if, expInstr);
      check("pcIf", pc_if, expPc);
      check("reqValid", {31'b0, imem_req_valid}, {31'b0, expReq});
      if (expReq) check("reqAddr", imem_req_addr, modelPc);
      if (prevHold) check("addrStable", imem_req_addr, prevAddr);
      acc = expReq && imem_req_ready;
      if (imem_rsp_valid) begin
         e = memQ.pop_front();
         if (!e.stale && !pc_src) bufQ.push_back('{pc: e.addr, instr: memData(e.addr)});
      end
      if (popM) void'(bufQ.pop_front());
      if (acc) memQ.push_back('{addr: modelPc, due: cycleNum + int'($urandom_range(latMin, latMax)), stale: pc_src});
      if (pc_src) begin
         foreach (memQ[i]) memQ[i].stale = 1;
         bufQ.delete();
         modelPc = new_pc & ~32'h3;
      end else if (acc) begin
         modelPc = modelPc + 32'h4;
      end
      prevHold = expReq && !imem_req_ready && !pc_src;
      prevAddr = imem_req_addr;
   endtask

   // Drive one cycle of inputs just after the rising edge, answer from the memory model, check at the falling edge.
   task automatic applyStimulus(input logic rstV, input logic stallV, input logic pcSrcV,
                                input logic [31:0] newPcV, input logic readyV);
      @(posedge clk);
      cycleNum++;
      #1;
      rst            = rstV;
      stall_if       = stallV;
      pc_src         = pcSrcV;
      new_pc         = newPcV;
      imem_req_ready = readyV;
      if (rstV && memQ.size() > 0 && memQ[0].due <= cycleNum) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memData(memQ[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      checkOutput();
   endtask

   task automatic firstValidPc(input string name, input logic [31:0] exp);
      bit found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
         if (lastValid) found = 1;
      end
      check(name, found ? lastPcIf : 32'hDEAD_BEEF, exp);
   endtask

   initial begin
      rst = 1'b0; stall_if = 1'b0; pc_src = 1'b0; new_pc = 32'h0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // Streaming from reset: requests 0,4,8 back to back, output starts at cycle 2.
      latMin = 1; latMax = 1;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
         if (c < 3) check("p1ReqAddr", lastReqAddr, 32'(c * 4));
         if (c >= 2) check("p1PcIf", lastPcIf, 32'((c - 2) * 4));
      end

      // Mid-stream reset, then a three-cycle stall with 0x0/0x4 buffered.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("midRstValid", {31'b0, lastValid}, 32'h0);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b1, (c >= 2 && c <= 4), 1'b0, 32'h0, 1'b1);
         if (c >= 2 && c <= 4) begin
            check("stallPcIf", lastPcIf, 32'h0);
            check("stallReqValid", {31'b0, lastReqValid}, 32'h0);
         end
         if (c == 6) check("afterStallPc4", lastPcIf, 32'h4);
         if (c == 7) check("afterStallPc8", lastPcIf, 32'h8);
      end

      // Latency 3, redirect to 0x100 with two requests outstanding.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      latMin = 3; latMax = 3;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
      check("k3FullCredit", {31'b0, lastReqValid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("k3StillFull", {31'b0, lastReqValid}, 32'h0);
      firstValidPc("k3FirstPc", 32'h100);

      // Redirect coinciding with an accept and a response; low target bits are ignored.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      latMin = 1; latMax = 1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h103, 1'b1);
      check("redirAccept", {31'b0, lastReqValid}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("redirEmpty", {31'b0, lastValid}, 32'h0);
      check("redirNop", lastInstr, 32'h0000_0013);
      firstValidPc("redirFirstPc", 32'h100);

      // PC wrap from the top of the address space.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, (c == 0), 32'hFFFF_FFFC, 1'b1);
         if (c == 1) check("wrapAddrTop", lastReqAddr, 32'hFFFF_FFFC);
         if (c == 2) check("wrapAddrZero", lastReqAddr, 32'h0);
         if (c == 3) check("wrapPcTop", lastPcIf, 32'hFFFF_FFFC);
         if (c == 4) check("wrapPcZero", lastPcIf, 32'h0);
      end

      // Random traffic: ready, stall, redirects, variable latency and occasional resets.
      latMin = 1; latMax = 3;
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom_range(0, 399) != 0),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 19) == 0),
                       $urandom,
                       ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
